// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes,
// opcode/funct constants and the 5-bit ALU control codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b01010;
  localparam logic [4:0] ALU_SLT = 5'b01011;
  localparam logic [4:0] ALU_NOR = 5'b11000;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRL = 5'b00101;

  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:                       return S_MEM_ADDR;
      OP_RTYPE:                           return S_R_EXEC;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: return S_I_EXEC;
      OP_BEQ:                             return S_BRANCH;
      OP_J:                               return S_JUMP;
      default:                            return S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational funct/opcode to ALU control decode.
// Shift functs (SLL/SRL) are only recognised when MIPS_CTRL_SHIFT_EN is defined.
module mips_alu_decoder (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [4:0] r_ctrl_o,
  output logic       r_valid_o,
  output logic [4:0] i_ctrl_o,
  output logic       i_zext_o
);
  import mips_ctrl_pkg::*;

`ifdef MIPS_CTRL_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  always_comb begin
    r_ctrl_o  = ALU_AND;
    r_valid_o = 1'b1;
    case (funct_i)
      FN_ADD, FN_ADDU: r_ctrl_o = ALU_ADD;
      FN_SUB, FN_SUBU: r_ctrl_o = ALU_SUB;
      FN_AND:          r_ctrl_o = ALU_AND;
      FN_OR:           r_ctrl_o = ALU_OR;
      FN_NOR:          r_ctrl_o = ALU_NOR;
      FN_SLT:          r_ctrl_o = ALU_SLT;
      FN_SLL: begin
        if (SHIFT_EN) r_ctrl_o = ALU_SLL;
        else          r_valid_o = 1'b0;
      end
      FN_SRL: begin
        if (SHIFT_EN) r_ctrl_o = ALU_SRL;
        else          r_valid_o = 1'b0;
      end
      default:         r_valid_o = 1'b0;
    endcase
  end

  always_comb begin
    i_ctrl_o = ALU_ADD;
    i_zext_o = 1'b0;
    case (opcode_i)
      OP_ANDI: begin
        i_ctrl_o = ALU_AND;
        i_zext_o = 1'b1;
      end
      OP_ORI: begin
        i_ctrl_o = ALU_OR;
        i_zext_o = 1'b1;
      end
      default: i_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: state register, opcode/funct latch, Moore output decode.
// Optional shift decode is enabled by MIPS_CTRL_SHIFT_EN (see mips_alu_decoder).
//
// state       | meaning
// FETCH       | read instruction at PC, PC+4 -> PC and IR load on memReady
// DECODE      | latch opcode/funct, branch target into ALUOut
// MEM_ADDR    | rs + sign-extended imm for lw/sw
// MEM_READ    | data read at ALUOut, held until memReady
// MEM_WB      | memory data -> rt
// MEM_WRITE   | data write at ALUOut, held until memReady
// R_EXEC      | rs op rt
// R_WB        | ALUOut -> rd
// I_EXEC      | rs op immediate
// I_WB        | ALUOut -> rt
// BRANCH      | rs - rt, PC <= ALUOut when zero
// JUMP        | PC <= jump target
// ILLEGAL     | unsupported instruction, parked until reset
module mips_multicycle_control #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       aluZero_i,
  input  logic       memReady_i,
  output logic       pcWrite_o,
  output logic       pcWriteCond_o,
  output logic [1:0] pcSource_o,
  output logic       iorD_o,
  output logic       memRead_o,
  output logic       memWrite_o,
  output logic       irWrite_o,
  output logic       regDst_o,
  output logic       memToReg_o,
  output logic       regWrite_o,
  output logic       aluSrcA_o,
  output logic [1:0] aluSrcB_o,
  output logic       extendZero_o,
  output logic [4:0] aluControl_o,
  output logic       aluCarryIn_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);
  import mips_ctrl_pkg::*;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("mips_multicycle_control: DATA_WIDTH must be 32");
  end

  state_t     state_q;
  logic [5:0] opcode_q;
  logic [5:0] funct_q;
  logic [4:0] r_ctrl;
  logic       r_valid;
  logic [4:0] i_ctrl;
  logic       i_zext;

  // The zero flag qualifies the PC write inside the datapath, not here.
  logic unused_alu_zero;
  assign unused_alu_zero = aluZero_i;

  mips_alu_decoder u_alu_dec (
    .opcode_i  (opcode_q),
    .funct_i   (funct_q),
    .r_ctrl_o  (r_ctrl),
    .r_valid_o (r_valid),
    .i_ctrl_o  (i_ctrl),
    .i_zext_o  (i_zext)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      case (state_q)
        S_FETCH:     if (memReady_i) state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q <= opcode_i;
          funct_q  <= funct_i;
          state_q  <= decode_next(opcode_i);
        end
        S_MEM_ADDR:  state_q <= (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (memReady_i) state_q <= S_MEM_WB;
        S_MEM_WRITE: if (memReady_i) state_q <= S_FETCH;
        S_R_EXEC:    state_q <= r_valid ? S_R_WB : S_ILLEGAL;
        S_I_EXEC:    state_q <= S_I_WB;
        S_ILLEGAL:   state_q <= S_ILLEGAL;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  assign state_o      = state_q;
  assign aluCarryIn_o = 1'b0;

  // Reset blanks every control so an aborted instruction cannot write anything.
  always_comb begin
    pcWrite_o     = 1'b0;
    pcWriteCond_o = 1'b0;
    pcSource_o    = 2'd0;
    iorD_o        = 1'b0;
    memRead_o     = 1'b0;
    memWrite_o    = 1'b0;
    irWrite_o     = 1'b0;
    regDst_o      = 1'b0;
    memToReg_o    = 1'b0;
    regWrite_o    = 1'b0;
    aluSrcA_o     = 1'b0;
    aluSrcB_o     = 2'd0;
    extendZero_o  = 1'b0;
    aluControl_o  = ALU_AND;
    illegal_o     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memRead_o    = 1'b1;
          aluSrcB_o    = 2'd1;
          aluControl_o = ALU_ADD;
          irWrite_o    = memReady_i;
          pcWrite_o    = memReady_i;
        end
        S_DECODE: begin
          aluSrcB_o    = 2'd3;
          aluControl_o = ALU_ADD;
        end
        S_MEM_ADDR: begin
          aluSrcA_o    = 1'b1;
          aluSrcB_o    = 2'd2;
          aluControl_o = ALU_ADD;
        end
        S_MEM_READ: begin
          iorD_o    = 1'b1;
          memRead_o = 1'b1;
        end
        S_MEM_WRITE: begin
          iorD_o     = 1'b1;
          memWrite_o = 1'b1;
        end
        S_MEM_WB: begin
          regWrite_o = 1'b1;
          memToReg_o = 1'b1;
        end
        S_R_EXEC: begin
          aluSrcA_o    = 1'b1;
          aluControl_o = r_ctrl;
        end
        S_R_WB: begin
          regWrite_o   = 1'b1;
          regDst_o     = 1'b1;
          aluControl_o = r_ctrl;
        end
        S_I_EXEC: begin
          aluSrcA_o    = 1'b1;
          aluSrcB_o    = 2'd2;
          aluControl_o = i_ctrl;
          extendZero_o = i_zext;
        end
        S_I_WB:      regWrite_o = 1'b1;
        S_BRANCH: begin
          aluSrcA_o     = 1'b1;
          aluControl_o  = ALU_SUB;
          pcWriteCond_o = 1'b1;
          pcSource_o    = 2'd1;
        end
        S_JUMP: begin
          pcWrite_o  = 1'b1;
          pcSource_o = 2'd2;
        end
        S_ILLEGAL:   illegal_o = 1'b1;
        default:     illegal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control; shift expectations follow MIPS_CTRL_SHIFT_EN.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       aluZero;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, aluSrcA, extendZero, aluCarryIn, illegal;
  logic [1:0] pcSource, aluSrcB;
  logic [4:0] aluControl;
  logic [3:0] state;
  logic [21:0] ctl;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control #(.DATA_WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .opcode_i      (opcode),
    .funct_i       (funct),
    .aluZero_i     (aluZero),
    .memReady_i    (memReady),
    .pcWrite_o     (pcWrite),
    .pcWriteCond_o (pcWriteCond),
    .pcSource_o    (pcSource),
    .iorD_o        (iorD),
    .memRead_o     (memRead),
    .memWrite_o    (memWrite),
    .irWrite_o     (irWrite),
    .regDst_o      (regDst),
    .memToReg_o    (memToReg),
    .regWrite_o    (regWrite),
    .aluSrcA_o     (aluSrcA),
    .aluSrcB_o     (aluSrcB),
    .extendZero_o  (extendZero),
    .aluControl_o  (aluControl),
    .aluCarryIn_o  (aluCarryIn),
    .illegal_o     (illegal),
    .state_o       (state)
  );

  assign ctl = {pcWrite, pcWriteCond, pcSource, iorD, memRead, memWrite, irWrite,
                regDst, memToReg, regWrite, aluSrcA, aluSrcB, extendZero,
                aluControl, aluCarryIn, illegal};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [4:0] A_AND = 5'b00000;
  localparam logic [4:0] A_OR  = 5'b00001;
  localparam logic [4:0] A_ADD = 5'b00010;
  localparam logic [4:0] A_SUB = 5'b01010;
  localparam logic [4:0] A_SLT = 5'b01011;
  localparam logic [4:0] A_SRL = 5'b00101;

  function automatic logic [21:0] mk(
    input logic pcw, input logic pcwc, input logic [1:0] pcs, input logic iord,
    input logic mr, input logic mw, input logic irw, input logic rdst,
    input logic m2r, input logic rw, input logic asa, input logic [1:0] asb,
    input logic ez, input logic [4:0] alu, input logic ill);
    return {pcw, pcwc, pcs, iord, mr, mw, irw, rdst, m2r, rw, asa, asb, ez, alu, 1'b0, ill};
  endfunction

  // Check state and full control vector for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [21:0] v);
    #1;
    checks++;
    assert (state === st) else begin
      errors++;
      $error("FAIL %s.state observed=%0d expected=%0d", tag, state, st);
    end
    checks++;
    assert (ctl === v) else begin
      errors++;
      $error("FAIL %s.ctl observed=%06h expected=%06h", tag, ctl, v);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic cyc_st(input string tag, input logic [3:0] st);
    #1;
    checks++;
    assert (state === st) else begin
      errors++;
      $error("FAIL %s.state observed=%0d expected=%0d", tag, state, st);
    end
    @(posedge clock);
    #1;
  endtask

  logic [21:0] v_zero, v_fr, v_fw, v_dec, v_ma, v_mr, v_mw, v_mwb;
  logic [21:0] v_rex_add, v_rwb_add, v_rex_slt, v_rwb_slt, v_rex_srl, v_rwb_srl;
  logic [21:0] v_iex_or, v_iwb, v_br, v_j, v_ill;

  initial begin
    v_zero    = 22'd0;
    v_fr      = mk(1'b1,1'b0,2'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,A_ADD,1'b0);
    v_fw      = mk(1'b0,1'b0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,1'b0,A_ADD,1'b0);
    v_dec     = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,1'b0,A_ADD,1'b0);
    v_ma      = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,1'b0,A_ADD,1'b0);
    v_mr      = mk(1'b0,1'b0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,A_AND,1'b0);
    v_mw      = mk(1'b0,1'b0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,A_AND,1'b0);
    v_mwb     = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,1'b0,A_AND,1'b0);
    v_rex_add = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,A_ADD,1'b0);
    v_rwb_add = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,1'b0,A_ADD,1'b0);
    v_rex_slt = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,A_SLT,1'b0);
    v_rwb_slt = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,1'b0,A_SLT,1'b0);
    v_rex_srl = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,A_SRL,1'b0);
    v_rwb_srl = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,1'b0,A_SRL,1'b0);
    v_iex_or  = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,1'b1,A_OR,1'b0);
    v_iwb     = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,1'b0,A_AND,1'b0);
    v_br      = mk(1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,1'b0,A_SUB,1'b0);
    v_j       = mk(1'b1,1'b0,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,A_AND,1'b0);
    v_ill     = mk(1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,A_AND,1'b1);

    reset = 1'b1; opcode = 6'h00; funct = 6'h00; aluZero = 1'b0; memReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    cyc("rst_init", S_FETCH, v_zero);
    reset = 1'b0;

    // sw interrupted by reset while waiting in MEM_WRITE
    memReady = 1'b1; opcode = 6'h2B;
    cyc("sw_fetch", S_FETCH, v_fr);
    cyc("sw_dec", S_DECODE, v_dec);
    cyc("sw_maddr", S_MEM_ADDR, v_ma);
    memReady = 1'b0;
    cyc("sw_wr0", S_MEM_WRITE, v_mw);
    cyc("sw_wr1", S_MEM_WRITE, v_mw);
    reset = 1'b1;
    cyc("rst_mw", S_MEM_WRITE, v_zero);
    cyc("rst_hold", S_FETCH, v_zero);
    reset = 1'b0;
    cyc("post_rst_wait", S_FETCH, v_fw);

    // add, inputs changed after DECODE must not matter
    memReady = 1'b1; opcode = 6'h00; funct = 6'h20;
    cyc("add_fetch", S_FETCH, v_fr);
    cyc("add_dec", S_DECODE, v_dec);
    opcode = 6'h3F; funct = 6'h3F;
    cyc("add_exec", S_R_EXEC, v_rex_add);
    cyc("add_wb", S_R_WB, v_rwb_add);

    // slt
    opcode = 6'h00; funct = 6'h2A;
    cyc("slt_fetch", S_FETCH, v_fr);
    cyc("slt_dec", S_DECODE, v_dec);
    cyc("slt_exec", S_R_EXEC, v_rex_slt);
    cyc("slt_wb", S_R_WB, v_rwb_slt);

    // lw with three wait cycles in MEM_READ
    opcode = 6'h23;
    cyc("lw_fetch", S_FETCH, v_fr);
    cyc("lw_dec", S_DECODE, v_dec);
    memReady = 1'b0;
    cyc("lw_maddr", S_MEM_ADDR, v_ma);
    cyc("lw_rd0", S_MEM_READ, v_mr);
    cyc("lw_rd1", S_MEM_READ, v_mr);
    cyc("lw_rd2", S_MEM_READ, v_mr);
    memReady = 1'b1;
    cyc("lw_rd3", S_MEM_READ, v_mr);
    cyc("lw_wb", S_MEM_WB, v_mwb);

    // beq taken then not taken
    opcode = 6'h04; aluZero = 1'b1;
    cyc("beq1_fetch", S_FETCH, v_fr);
    cyc("beq1_dec", S_DECODE, v_dec);
    cyc("beq1_br", S_BRANCH, v_br);
    aluZero = 1'b0;
    cyc("beq0_fetch", S_FETCH, v_fr);
    cyc("beq0_dec", S_DECODE, v_dec);
    cyc("beq0_br", S_BRANCH, v_br);

    // ori
    opcode = 6'h0D;
    cyc("ori_fetch", S_FETCH, v_fr);
    cyc("ori_dec", S_DECODE, v_dec);
    cyc("ori_exec", S_I_EXEC, v_iex_or);
    cyc("ori_wb", S_I_WB, v_iwb);

    // j
    opcode = 6'h02;
    cyc("j_fetch", S_FETCH, v_fr);
    cyc("j_dec", S_DECODE, v_dec);
    cyc("j_jump", S_JUMP, v_j);

    // srl: decoded only with the shift option
    opcode = 6'h00; funct = 6'h02;
    cyc("srl_fetch", S_FETCH, v_fr);
    cyc("srl_dec", S_DECODE, v_dec);
`ifdef MIPS_CTRL_SHIFT_EN
    cyc("srl_exec", S_R_EXEC, v_rex_srl);
    cyc("srl_wb", S_R_WB, v_rwb_srl);
    cyc("srl_next", S_FETCH, v_fr);
`else
    cyc_st("srl_exec", S_R_EXEC);
    cyc("srl_ill", S_ILLEGAL, v_ill);
    cyc("srl_ill_hold", S_ILLEGAL, v_ill);
`endif
    reset = 1'b1;
    cyc_st("rst_srl", state);
    cyc("rst_srl_hold", S_FETCH, v_zero);
    reset = 1'b0;

    // unsupported opcode parks in ILLEGAL until reset
    memReady = 1'b1; opcode = 6'h3F;
    cyc("ill_fetch", S_FETCH, v_fr);
    cyc("ill_dec", S_DECODE, v_dec);
    for (int i = 0; i < 10; i++) begin
      memReady = i[0];
      cyc("ill_park", S_ILLEGAL, v_ill);
    end
    reset = 1'b1;
    cyc("ill_rst", S_ILLEGAL, v_zero);
    reset = 1'b0; memReady = 1'b1;
    cyc("ill_cleared", S_FETCH, v_fr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
